// File: rtl/adder_seq_arbiter_pkg.sv
// Shared constants and types for the sequenced wide-add arbiter.
// Slice width, FSM state encoding and requester ids.
package adder_seq_arbiter_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_16bit.sv
// One 16-bit ripple slice of the shared adder datapath.
// Purely combinational: sum and carry-out of a + b + cin.
module adder_16bit
  import adder_seq_arbiter_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder between two requesters.
// Wide adds are sequenced low-to-high, one slice per cycle, carry chained in a register.
module adder_seq_arbiter
  import adder_seq_arbiter_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [SLICE_W*WORDS-1:0]   req0_a,
  input  logic [SLICE_W*WORDS-1:0]   req0_b,
  input  logic                       req0_cin,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [SLICE_W*WORDS-1:0]   req1_a,
  input  logic [SLICE_W*WORDS-1:0]   req1_b,
  input  logic                       req1_cin,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_id,
  output logic [SLICE_W*WORDS-1:0]   res_sum,
  output logic                       res_cout
);

  localparam int W    = SLICE_W * WORDS;
  localparam int IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic                carry_r;
  logic [IDXW-1:0]     idx_r;
  logic                last_grant_r;
  logic                grant_s;
  logic                accept_s;
  logic [SLICE_W-1:0]  a_slice_s;
  logic [SLICE_W-1:0]  b_slice_s;
  logic [SLICE_W-1:0]  sum_slice_s;
  logic                cout_slice_s;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_s = REQ0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = REQ1;
    end else begin
      grant_s = REQ0;
    end
  end

  // Ready is offered only while idle, and never while reset is being applied.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      req0_ready = req0_valid && (grant_s == REQ0);
      req1_ready = req1_valid && (grant_s == REQ1);
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign accept_s  = req0_ready | req1_ready;
  assign a_slice_s = a_r[int'(idx_r)*SLICE_W +: SLICE_W];
  assign b_slice_s = b_r[int'(idx_r)*SLICE_W +: SLICE_W];

  adder_16bit u_slice (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_r),
    .sum  (sum_slice_s),
    .cout (cout_slice_s)
  );

  // Next-state logic for the accept / run / result-hold sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_nxt_s = DONE;
        else                   state_nxt_s = RUN;
      end
      DONE: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand capture, slice sequencing and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      carry_r      <= 1'b0;
      idx_r        <= {IDXW{1'b0}};
      last_grant_r <= REQ1;
      res_valid    <= 1'b0;
      res_id       <= REQ0;
      res_sum      <= {W{1'b0}};
      res_cout     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r          <= (grant_s == REQ1) ? req1_a   : req0_a;
            b_r          <= (grant_s == REQ1) ? req1_b   : req0_b;
            carry_r      <= (grant_s == REQ1) ? req1_cin : req0_cin;
            last_grant_r <= grant_s;
            res_id       <= grant_s;
            idx_r        <= {IDXW{1'b0}};
            res_sum      <= {W{1'b0}};
          end
        end
        RUN: begin
          res_sum[int'(idx_r)*SLICE_W +: SLICE_W] <= sum_slice_s;
          carry_r <= cout_slice_s;
          if (idx_r == LAST_IDX) begin
            // Park the index at 0 so the slice mux never selects past the operand.
            idx_r     <= {IDXW{1'b0}};
            res_cout  <= cout_slice_s;
            res_valid <= 1'b1;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Self-checking bench for adder_seq_arbiter: directed cases plus randomized ops
// compared against a plain-arithmetic reference with a round-robin grant model.
module tb_adder_seq_arbiter;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         res_valid, res_ready = 1'b0, res_id, res_cout;
  logic [W-1:0] res_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last   = 1'b1;   // reference: requester granted most recently

  always #5 clk = ~clk;

  adder_seq_arbiter #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
  );

  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom(), $urandom()};
  endfunction

  // One full transaction: offer, accept, wait for result, optional backpressure, handshake.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                        input int hold);
    bit           exp_id;
    logic [W:0]   exp_full;
    logic [W-1:0] snap;
    int           n;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    res_ready  = 1'b0;
    #1;
    exp_id   = (v0 && v1) ? ~m_last : v1;
    exp_full = exp_id ? ref_add(a1, b1, c1) : ref_add(a0, b0, c0);
    check_val("ready0_offer", req0_ready, v0 && !exp_id);
    check_val("ready1_offer", req1_ready, v1 && exp_id);
    m_last = exp_id;
    tick();
    // Scramble the operands right after accept; only captured values may count.
    req0_a = rnd_w(); req0_b = rnd_w(); req0_cin = 1'($urandom_range(0, 1));
    req1_a = rnd_w(); req1_b = rnd_w(); req1_cin = 1'($urandom_range(0, 1));
    n = 0;
    while (!res_valid && n < 4 * WORDS) begin
      check_val("ready_run", {req0_ready, req1_ready}, 2'b00);
      tick();
      n++;
    end
    check_val("latency", n, WORDS);
    check_val("sum", res_sum, exp_full[W-1:0]);
    check_val("cout", res_cout, exp_full[W]);
    check_val("id", res_id, exp_id);
    snap = exp_full[W-1:0];
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val("hold", {res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready},
                {1'b1, exp_id, exp_full[W], snap, 2'b00});
    end
    res_ready = 1'b1;
    tick();
    check_val("valid_drop", res_valid, 1'b0);
    res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with both requesters asking so ready gating is exercised.
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", res_valid, 1'b0);
    check_val("rst_sum", res_sum, {W{1'b0}});
    check_val("rst_cout", res_cout, 1'b0);
    check_val("rst_id", res_id, 1'b0);
    check_val("rst_ready", {req0_ready, req1_ready}, 2'b00);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
    tick();

    // Both valid from reset: grants 0, 1, 0.
    for (int i = 0; i < 3; i++)
      run_op(1'b1, 1'b1, rnd_w(), rnd_w(), 1'b0, rnd_w(), rnd_w(), 1'b1, 0);

    // Carry out of slice 0 into slice 1.
    run_op(1'b1, 1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0,
           rnd_w(), rnd_w(), 1'b0, 0);
    // Carry-in ripples through all slices.
    run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, rnd_w(), rnd_w(), 1'b0, 0);
    // Same ripple from requester 1 alone.
    run_op(1'b0, 1'b1, rnd_w(), rnd_w(), 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
    // Backpressure for 10 cycles with both requesters waiting.
    run_op(1'b1, 1'b1, rnd_w(), rnd_w(), 1'b1, rnd_w(), rnd_w(), 1'b0, 10);
    run_op(1'b1, 1'b1, rnd_w(), rnd_w(), 1'b0, rnd_w(), rnd_w(), 1'b0, 0);

    // Reset in the slice-2 cycle of a running operation.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = rnd_w(); req0_b = rnd_w(); req1_a = rnd_w(); req1_b = rnd_w();
    #1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_val("midrst_valid", res_valid, 1'b0);
    check_val("midrst_sum", res_sum, {W{1'b0}});
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < WORDS + 2; i++) begin
      check_val("no_stale", res_valid, 1'b0);
      tick();
    end
    run_op(1'b1, 1'b1, rnd_w(), rnd_w(), 1'b0, rnd_w(), rnd_w(), 1'b0, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      bit           v0, v1;
      logic [W-1:0] a0;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = (k % 8 == 0) ? {W{1'b1}} : rnd_w();
      run_op(v0, v1, a0, rnd_w(), 1'($urandom_range(0, 1)),
             rnd_w(), rnd_w(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
